pic_io_bank: RTL and testbench

//   Parametrised GPIO bank for the PIC16C5x core family: NUM_PORTS ports of PORT_WIDTH bits each.

---
 rtl/pic_io_pkg.sv | 21 ++
 rtl/pic_io_bank_if.sv | 33 +++
 rtl/pic_io_sync.sv | 27 ++
 rtl/pic_io_bank.sv | 120 ++++++++++++
 tb/tb_pic_io_bank.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/pic_io_pkg.sv
// pic_io_pkg: shared constants, types and helpers for the PIC16C5x GPIO bank.
package pic_io_pkg;

  // Widest port the bank supports and the width of every port-select field.
  localparam int MAX_PORTS = 8;
  localparam int MAX_WIDTH = 8;
  localparam int SEL_WIDTH = 3;

  // One full-width port value; narrower ports use the low bits.
  typedef logic [MAX_WIDTH-1:0] port_t;

  // After reset every pin is an input and every output latch is clear.
  localparam port_t TRIS_RESET = '1;
  localparam port_t LAT_RESET  = '0;

  // Lowest bit of port p inside a flattened pad vector.
  function automatic int pad_lo(input int p, input int width);
    return p * width;
  endfunction

endpackage

// File: rtl/pic_io_bank_if.sv
// pic_io_bank_if: register-file / pad-side bundle of the GPIO bank.
// master = core and chip top side, slave = pic_io_bank.
interface pic_io_bank_if #(
  parameter int NUM_PORTS  = 3,
  parameter int PORT_WIDTH = 8
);
  logic                            tris_we;
  logic [2:0]                      tris_sel;
  logic [PORT_WIDTH-1:0]           tris_data;
  logic                            out_we;
  logic [2:0]                      out_sel;
  logic [PORT_WIDTH-1:0]           out_data;
  logic [2:0]                      rd_sel;
  logic                            rd_strobe;
  logic                            ioc_we;
  logic [NUM_PORTS*PORT_WIDTH-1:0] pad_in;
  logic [NUM_PORTS*PORT_WIDTH-1:0] pad_out;
  logic [NUM_PORTS*PORT_WIDTH-1:0] pad_oe;
  logic [PORT_WIDTH-1:0]           rd_data;
  logic                            irq;

  modport master (
    output tris_we, tris_sel, tris_data, out_we, out_sel, out_data,
    output rd_sel, rd_strobe, ioc_we, pad_in,
    input  pad_out, pad_oe, rd_data, irq
  );

  modport slave (
    input  tris_we, tris_sel, tris_data, out_we, out_sel, out_data,
    input  rd_sel, rd_strobe, ioc_we, pad_in,
    output pad_out, pad_oe, rd_data, irq
  );
endinterface

// File: rtl/pic_io_sync.sv
// pic_io_sync: STAGES-deep flop chain that brings WIDTH asynchronous pad bits
// into the core clock domain.
module pic_io_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  // Shift the pad sample one stage per clock; reset clears the whole chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pic_io_bank.sv
// pic_io_bank: NUM_PORTS x PORT_WIDTH GPIO bank with TRIS and output latches,
// synchronised pad inputs and combinational port read-back.
// Optional interrupt-on-change logic is compiled in with `define PIC_IO_IOC_EN.
module pic_io_bank
  import pic_io_pkg::*;
#(
  parameter int NUM_PORTS   = 3,
  parameter int PORT_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  pic_io_bank_if.slave  bus
);

  typedef logic [PORT_WIDTH-1:0] word_t;

  word_t tris_q [NUM_PORTS];
  word_t lat_q  [NUM_PORTS];
  word_t sync_w [NUM_PORTS];

  logic [NUM_PORTS*PORT_WIDTH-1:0] pad_out_d;
  logic [NUM_PORTS*PORT_WIDTH-1:0] pad_oe_d;
  word_t                           rd_data_d;

  // Per-port latches and input synchroniser. A select that matches no port
  // (>= NUM_PORTS) simply writes nothing.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    // TRIS and output latch; both may be written in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        tris_q[gi] <= TRIS_RESET[PORT_WIDTH-1:0];
        lat_q[gi]  <= LAT_RESET[PORT_WIDTH-1:0];
      end else begin
        if (bus.tris_we && (bus.tris_sel == SEL_WIDTH'(gi)))
          tris_q[gi] <= bus.tris_data;
        if (bus.out_we && (bus.out_sel == SEL_WIDTH'(gi)))
          lat_q[gi] <= bus.out_data;
      end
    end

    pic_io_sync #(
      .WIDTH  (PORT_WIDTH),
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (bus.pad_in[pad_lo(gi, PORT_WIDTH) +: PORT_WIDTH]),
      .q_o (sync_w[gi])
    );
  end

  // Flatten latches onto the pad vectors; output enable is the TRIS inverse.
  always_comb begin
    pad_out_d = '0;
    pad_oe_d  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      pad_out_d[pad_lo(p, PORT_WIDTH) +: PORT_WIDTH] = lat_q[p];
      pad_oe_d[pad_lo(p, PORT_WIDTH) +: PORT_WIDTH]  = ~tris_q[p];
    end
  end

  // Read returns the synchronised pin, never the latch, so read-modify-write
  // on an output port sees what the pin is actually doing.
  always_comb begin
    rd_data_d = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (bus.rd_sel == SEL_WIDTH'(p)) rd_data_d = sync_w[p];
    end
  end

  assign bus.pad_out = pad_out_d;
  assign bus.pad_oe  = pad_oe_d;
  assign bus.rd_data = rd_data_d;

`ifdef PIC_IO_IOC_EN
  word_t                mask_q [NUM_PORTS];
  word_t                snap_q [NUM_PORTS];
  logic [NUM_PORTS-1:0] chg;
  logic                 irq_q;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ioc
    // IOC mask shares the out_sel/out_data path; snapshot reloads on a read.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mask_q[gi] <= '0;
        snap_q[gi] <= '0;
      end else begin
        if (bus.ioc_we && (bus.out_sel == SEL_WIDTH'(gi)))
          mask_q[gi] <= bus.out_data;
        if (bus.rd_strobe && (bus.rd_sel == SEL_WIDTH'(gi)))
          snap_q[gi] <= sync_w[gi];
      end
    end
  end

  // A port being read this cycle reloads its snapshot with the current value,
  // so any difference it shows now is already acknowledged.
  always_comb begin
    chg = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      chg[p] = (|((sync_w[p] ^ snap_q[p]) & mask_q[p])) &&
               !(bus.rd_strobe && (bus.rd_sel == SEL_WIDTH'(p)));
    end
  end

  // Registered interrupt request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= |chg;
  end

  assign bus.irq = irq_q;
`else
  logic unused_ioc;
  assign unused_ioc = ^{bus.ioc_we, bus.rd_strobe};
  assign bus.irq    = 1'b0;
`endif

endmodule

// File: tb/tb_pic_io_bank.sv
// tb_pic_io_bank: directed checks of the GPIO bank (3 ports x 8 bits, 2 sync stages).
module tb_pic_io_bank;
  import pic_io_pkg::*;

  localparam int NP   = 3;
  localparam int PW   = 8;
  localparam int SYNC = 2;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  pic_io_bank_if #(.NUM_PORTS(NP), .PORT_WIDTH(PW)) bus ();

  pic_io_bank #(
    .NUM_PORTS   (NP),
    .PORT_WIDTH  (PW),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance past one rising edge, landing 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    bus.tris_we   = 1'b0;
    bus.out_we    = 1'b0;
    bus.ioc_we    = 1'b0;
    bus.rd_strobe = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    clear_strobes();
    bus.tris_sel  = '0;
    bus.tris_data = '0;
    bus.out_sel   = '0;
    bus.out_data  = '0;
    bus.rd_sel    = '0;
    bus.pad_in    = '0;

    // Reset state
    #12;
    chk("rst_oe",  32'(bus.pad_oe),  32'h0);
    chk("rst_out", 32'(bus.pad_out), 32'h0);
    chk("rst_rd",  32'(bus.rd_data), 32'h0);
    chk("rst_irq", 32'(bus.irq),     32'h0);
    rst = 1'b0;
    step();

    // TRIS write to port 1, then latch write to port 1
    bus.tris_we = 1'b1; bus.tris_sel = 3'd1; bus.tris_data = 8'hF0;
    #2;
    chk("tris_before_edge", 32'(bus.pad_oe[15:8]), 32'h00);
    step();
    clear_strobes();
    $display("txn: tris_we sel=1 data=F0");
    chk("tris_p1_oe", 32'(bus.pad_oe[15:8]), 32'h0F);
    bus.out_we = 1'b1; bus.out_sel = 3'd1; bus.out_data = 8'hA5;
    step();
    clear_strobes();
    $display("txn: out_we sel=1 data=A5");
    chk("lat_p1_out", 32'(bus.pad_out[15:8]), 32'hA5);
    chk("lat_p1_oe_kept", 32'(bus.pad_oe[15:8]), 32'h0F);

    // Input synchroniser latency on port 2
    bus.pad_in[23:16] = 8'h3C;
    bus.rd_sel = 3'd2;
    $display("txn: pad_in p2=3C rd_sel=2");
    for (int i = 0; i < SYNC - 1; i++) begin
      step();
      chk("sync_early", 32'(bus.rd_data), 32'h00);
    end
    step();
    chk("sync_p2", 32'(bus.rd_data), 32'h3C);

    // Output-mode bits read the pin, not the latch (port 1 latch = A5)
    bus.pad_in[15:8] = 8'h5A;
    bus.rd_sel = 3'd1;
    $display("txn: pad_in p1=5A rd_sel=1");
    repeat (SYNC) step();
    chk("readback_pin", 32'(bus.rd_data), 32'h5A);

    // Simultaneous TRIS and latch write to port 0
    bus.tris_we = 1'b1; bus.tris_sel = 3'd0; bus.tris_data = 8'h00;
    bus.out_we  = 1'b1; bus.out_sel  = 3'd0; bus.out_data  = 8'hFF;
    step();
    clear_strobes();
    $display("txn: tris_we+out_we sel=0 tris=00 out=FF");
    chk("dual_p0_oe",  32'(bus.pad_oe[7:0]),  32'hFF);
    chk("dual_p0_out", 32'(bus.pad_out[7:0]), 32'hFF);

    // Out-of-range selects
    bus.tris_we = 1'b1; bus.tris_sel = 3'd5; bus.tris_data = 8'h00;
    bus.out_we  = 1'b1; bus.out_sel  = 3'd5; bus.out_data  = 8'h11;
    bus.rd_sel  = 3'd5;
    step();
    clear_strobes();
    $display("txn: tris_we/out_we/rd_sel sel=5");
    chk("oor_oe",  32'(bus.pad_oe),  32'h000FFF);
    chk("oor_out", 32'(bus.pad_out), 32'h00A5FF);
    chk("oor_rd",  32'(bus.rd_data), 32'h00);

`ifdef PIC_IO_IOC_EN
    // Interrupt-on-change on port 0 bit 0
    bus.rd_sel = 3'd0; bus.rd_strobe = 1'b1;
    bus.ioc_we = 1'b1; bus.out_sel = 3'd0; bus.out_data = 8'h01;
    step();
    clear_strobes();
    $display("txn: ioc mask p0=01, rd_strobe sel=0");
    bus.pad_in[7:0] = 8'h01;
    $display("txn: toggle pad p0 bit0");
    repeat (SYNC) step();
    chk("ioc_not_yet", 32'(bus.irq), 32'h0);
    step();
    chk("ioc_irq_set", 32'(bus.irq), 32'h1);
    bus.rd_sel = 3'd0; bus.rd_strobe = 1'b1;
    step();
    clear_strobes();
    $display("txn: rd_strobe sel=0");
    chk("ioc_irq_clr", 32'(bus.irq), 32'h0);
    bus.pad_in[7:0] = 8'h03;
    $display("txn: toggle unmasked pad p0 bit1");
    repeat (SYNC + 2) step();
    chk("ioc_unmasked", 32'(bus.irq), 32'h0);
`else
    // Without the option irq never rises, even on a change after a read
    bus.rd_sel = 3'd0; bus.rd_strobe = 1'b1; bus.ioc_we = 1'b1;
    bus.out_sel = 3'd0; bus.out_data = 8'h01;
    step();
    clear_strobes();
    bus.pad_in[7:0] = 8'h01;
    $display("txn: ioc_we/rd_strobe/toggle without IOC option");
    repeat (SYNC + 2) step();
    chk("no_ioc_irq", 32'(bus.irq), 32'h0);
    chk("no_ioc_lat", 32'(bus.pad_out[7:0]), 32'hFF);
`endif

    // Asynchronous reset mid-run, sampled before the next clock edge
    bus.rd_sel = 3'd2;
    step();
    chk("pre_rst_rd", 32'(bus.rd_data), 32'h3C);
    rst = 1'b1;
    #2;
    $display("txn: async rst mid-cycle");
    chk("mid_rst_oe",  32'(bus.pad_oe),  32'h0);
    chk("mid_rst_out", 32'(bus.pad_out), 32'h0);
    chk("mid_rst_rd",  32'(bus.rd_data), 32'h0);
    chk("mid_rst_irq", 32'(bus.irq),     32'h0);
    #2;
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
